// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master main-RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } ram_arb_state_t;

  typedef logic master_idx_t;

  localparam master_idx_t M0 = 1'b0;
  localparam master_idx_t M1 = 1'b1;

endpackage

// File: rtl/ram_arb.sv
// Round-robin arbiter serializing two masters' whole transactions onto one RAM port.
// Each master sees a plain RAM with wait states via its own READYn.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW = 21,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 4
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          CE,
  input  logic [AW-1:0] M0_A,
  input  logic [DW-1:0] M0_DI,
  output logic [DW-1:0] M0_DO,
  input  logic          M0_CEn,
  input  logic          M0_WEn,
  input  logic [BW-1:0] M0_BEn,
  output logic          M0_READYn,
  input  logic [AW-1:0] M1_A,
  input  logic [DW-1:0] M1_DI,
  output logic [DW-1:0] M1_DO,
  input  logic          M1_CEn,
  input  logic          M1_WEn,
  input  logic [BW-1:0] M1_BEn,
  output logic          M1_READYn,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO,
  output logic          RAM_CEn,
  output logic          RAM_WEn,
  output logic [BW-1:0] RAM_BEn,
  input  logic          RAM_READYn,
  output logic [1:0]    GNT
);

  ram_arb_state_t state, next_state;
  master_idx_t    last, next_last;

  logic req0, req1;
  assign req0 = ~M0_CEn;
  assign req1 = ~M1_CEn;

  // A lone requester wins; on a tie the master not served last wins.
  function automatic master_idx_t rr_pick(input logic r0, input logic r1,
                                          input master_idx_t prev);
    if (r0 && !r1) return M0;
    if (r1 && !r0) return M1;
    return (prev == M0) ? M1 : M0;
  endfunction

  // State and last-served pointer; advance only on CE edges.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state <= IDLE;
      last  <= M1;
    end else if (CE) begin
      state <= next_state;
      last  <= next_last;
    end
  end

  // Completion wins over abort when READYn and a dropped CEn coincide;
  // the just-served master's CEn is not looked at on its completion edge.
  always_comb begin
    next_state = state;
    next_last  = last;
    case (state)
      IDLE: begin
        if (req0 || req1)
          next_state = (rr_pick(req0, req1, last) == M0) ? GNT0 : GNT1;
      end
      GNT0: begin
        if (!RAM_READYn) begin
          next_last  = M0;
          next_state = req1 ? GNT1 : IDLE;
        end else if (!req0) begin
          next_state = IDLE;
        end
      end
      GNT1: begin
        if (!RAM_READYn) begin
          next_last  = M1;
          next_state = req0 ? GNT0 : IDLE;
        end else if (!req1) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // RAM port mux and per-master ready, decoded from the registered grant.
  always_comb begin
    RAM_A     = M0_A;
    RAM_DI    = M0_DI;
    RAM_CEn   = 1'b1;
    RAM_WEn   = 1'b1;
    RAM_BEn   = {BW{1'b1}};
    M0_READYn = 1'b1;
    M1_READYn = 1'b1;
    GNT       = 2'b00;
    case (state)
      GNT0: begin
        RAM_CEn   = 1'b0;
        RAM_WEn   = M0_WEn;
        RAM_BEn   = M0_BEn;
        M0_READYn = RAM_READYn;
        GNT       = 2'b01;
      end
      GNT1: begin
        RAM_A     = M1_A;
        RAM_DI    = M1_DI;
        RAM_CEn   = 1'b0;
        RAM_WEn   = M1_WEn;
        RAM_BEn   = M1_BEn;
        M1_READYn = RAM_READYn;
        GNT       = 2'b10;
      end
      default: ;
    endcase
  end

  assign M0_DO = RAM_DO;
  assign M1_DO = RAM_DO;

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: reset, single access, back-to-back, round-robin,
// clock-enable gating and asynchronous reset during a grant.
module tb_ram_arb;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          CLK, RES, CE;
  logic [AW-1:0] M0_A, M1_A, RAM_A;
  logic [DW-1:0] M0_DI, M1_DI, M0_DO, M1_DO, RAM_DI, RAM_DO;
  logic          M0_CEn, M0_WEn, M0_READYn;
  logic          M1_CEn, M1_WEn, M1_READYn;
  logic [BW-1:0] M0_BEn, M1_BEn, RAM_BEn;
  logic          RAM_CEn, RAM_WEn, RAM_READYn;
  logic [1:0]    GNT;

  int checks   = 0;
  int failures = 0;
  int c0, c1;

  ram_arb #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .CLK(CLK), .RES(RES), .CE(CE),
    .M0_A(M0_A), .M0_DI(M0_DI), .M0_DO(M0_DO), .M0_CEn(M0_CEn),
    .M0_WEn(M0_WEn), .M0_BEn(M0_BEn), .M0_READYn(M0_READYn),
    .M1_A(M1_A), .M1_DI(M1_DI), .M1_DO(M1_DO), .M1_CEn(M1_CEn),
    .M1_WEn(M1_WEn), .M1_BEn(M1_BEn), .M1_READYn(M1_READYn),
    .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO), .RAM_CEn(RAM_CEn),
    .RAM_WEn(RAM_WEn), .RAM_BEn(RAM_BEn), .RAM_READYn(RAM_READYn),
    .GNT(GNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RES = 1'b1; CE = 1'b1;
    M0_A = '0; M0_DI = '0; M0_CEn = 1'b1; M0_WEn = 1'b1; M0_BEn = 4'hF;
    M1_A = '0; M1_DI = '0; M1_CEn = 1'b1; M1_WEn = 1'b1; M1_BEn = 4'hF;
    RAM_DO = '0; RAM_READYn = 1'b1;
    step(); step();
    RES = 1'b0;
    step();

    // reset state
    check("rst_ram_cen", 32'(RAM_CEn), 32'h1);
    check("rst_gnt", 32'(GNT), 32'h0);
    check("rst_m0_ready", 32'(M0_READYn), 32'h1);
    check("rst_m1_ready", 32'(M1_READYn), 32'h1);
    check("rst_ram_ben", 32'(RAM_BEn), 32'hF);
    check("rst_ram_wen", 32'(RAM_WEn), 32'h1);

    // M0 read, three wait cycles
    M0_A = 21'h00100; M0_CEn = 1'b0; M0_WEn = 1'b1; M0_BEn = 4'h0;
    step();
    check("rd_gnt", 32'(GNT), 32'h1);
    check("rd_ram_cen", 32'(RAM_CEn), 32'h0);
    check("rd_ram_a", 32'(RAM_A), 32'h00100);
    check("rd_ready_w1", 32'(M0_READYn), 32'h1);
    step();
    check("rd_ready_w2", 32'(M0_READYn), 32'h1);
    step();
    check("rd_ready_w3", 32'(M0_READYn), 32'h1);
    RAM_READYn = 1'b0; RAM_DO = 32'hDEADBEEF;
    #1;
    check("rd_ready_done", 32'(M0_READYn), 32'h0);
    check("rd_m0_do", M0_DO, 32'hDEADBEEF);
    check("rd_m1_ready", 32'(M1_READYn), 32'h1);
    step();
    M0_CEn = 1'b1; RAM_READYn = 1'b1;
    #1;
    check("rd_idle_gnt", 32'(GNT), 32'h0);
    check("rd_idle_ready", 32'(M0_READYn), 32'h1);
    check("rd_idle_cen", 32'(RAM_CEn), 32'h1);

    // simultaneous writes right after reset
    RES = 1'b1; step(); RES = 1'b0; step();
    M0_A = 21'h00200; M0_DI = 32'hAAAA5555; M0_WEn = 1'b0; M0_BEn = 4'h0; M0_CEn = 1'b0;
    M1_A = 21'h1FFFF; M1_DI = 32'h12345678; M1_WEn = 1'b0; M1_BEn = 4'b1100; M1_CEn = 1'b0;
    step();
    check("wr_first_gnt", 32'(GNT), 32'h1);
    check("wr_m0_a", 32'(RAM_A), 32'h00200);
    check("wr_m0_wen", 32'(RAM_WEn), 32'h0);
    step();
    RAM_READYn = 1'b0;
    #1;
    check("wr_m0_done", 32'(M0_READYn), 32'h0);
    check("wr_m1_wait", 32'(M1_READYn), 32'h1);
    step();
    M0_CEn = 1'b1; RAM_READYn = 1'b1;
    #1;
    check("wr_b2b_gnt", 32'(GNT), 32'h2);
    check("wr_b2b_cen", 32'(RAM_CEn), 32'h0);
    check("wr_m1_a", 32'(RAM_A), 32'h1FFFF);
    check("wr_m1_di", RAM_DI, 32'h12345678);
    check("wr_m1_wen", 32'(RAM_WEn), 32'h0);
    check("wr_m1_ben", 32'(RAM_BEn), 32'hC);
    step();
    RAM_READYn = 1'b0;
    #1;
    check("wr_m1_done", 32'(M1_READYn), 32'h0);
    check("wr_m0_quiet", 32'(M0_READYn), 32'h1);
    step();
    M1_CEn = 1'b1; RAM_READYn = 1'b1;
    #1;
    check("wr_idle_gnt", 32'(GNT), 32'h0);

    // ten back-to-back requests from each master, zero-wait RAM
    c0 = 0; c1 = 0;
    M0_WEn = 1'b1; M1_WEn = 1'b1;
    M0_CEn = 1'b0; M1_CEn = 1'b0; RAM_READYn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("rr_gnt", 32'(GNT), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (M0_READYn == 1'b0) begin
        c0++;
        if (c0 == 10) M0_CEn = 1'b1;
      end
      if (M1_READYn == 1'b0) begin
        c1++;
        if (c1 == 10) M1_CEn = 1'b1;
      end
    end
    step();
    check("rr_idle_gnt", 32'(GNT), 32'h0);
    check("rr_idle_ready0", 32'(M0_READYn), 32'h1);
    check("rr_idle_ready1", 32'(M1_READYn), 32'h1);
    check("rr_m0_pulses", 32'(c0), 32'd10);
    check("rr_m1_pulses", 32'(c1), 32'd10);
    RAM_READYn = 1'b1;

    // clock enable 1-of-3 during a GNT1 transfer
    M1_CEn = 1'b0;
    step();
    check("ce_gnt", 32'(GNT), 32'h2);
    CE = 1'b0; RAM_READYn = 1'b0;
    #1;
    check("ce_comb_ready", 32'(M1_READYn), 32'h0);
    step();
    check("ce_hold1", 32'(GNT), 32'h2);
    step();
    check("ce_hold2", 32'(GNT), 32'h2);
    CE = 1'b1;
    step();
    CE = 1'b0; M1_CEn = 1'b1;
    #1;
    check("ce_done_gnt", 32'(GNT), 32'h0);
    check("ce_done_ready", 32'(M1_READYn), 32'h1);
    step(); step();
    CE = 1'b1;
    step();
    check("ce_no_double", 32'(GNT), 32'h0);
    check("ce_no_double_rdy", 32'(M1_READYn), 32'h1);
    RAM_READYn = 1'b1;

    // async reset during GNT0, M0 still requesting
    M0_CEn = 1'b0;
    step();
    check("rs_gnt0", 32'(GNT), 32'h1);
    M1_CEn = 1'b0; CE = 1'b0;
    #1 RES = 1'b1;
    #1;
    check("rs_async_cen", 32'(RAM_CEn), 32'h1);
    check("rs_async_gnt", 32'(GNT), 32'h0);
    step();
    RES = 1'b0; CE = 1'b1;
    step();
    check("rs_m0_first", 32'(GNT), 32'h1);

    // async reset again; M0 withdraws, so pending M1 goes first
    #1 RES = 1'b1; M0_CEn = 1'b1;
    step();
    RES = 1'b0;
    step();
    check("rs_m1_first", 32'(GNT), 32'h2);
    check("rs_m1_a", 32'(RAM_A), 32'h1FFFF);
    RAM_READYn = 1'b0; RAM_DO = 32'hCAFEF00D;
    #1;
    check("rs_m1_ready", 32'(M1_READYn), 32'h0);
    check("rs_m1_do", M1_DO, 32'hCAFEF00D);
    step();
    M1_CEn = 1'b1; RAM_READYn = 1'b1;
    #1;
    check("rs_idle_gnt", 32'(GNT), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
